hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_detect.sv | 23 ++
 rtl/hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package for the ID/EX/MEM control blocks.
// Holds the opcode constants the hazard logic decodes, the hazard FSM
// state encoding and a small register-compare helper.
package hazard_ctrl_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_STU  = 5'b10011;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  // True when a qualified source register reads the given destination.
  function automatic logic reg_match(input logic       uses,
                                     input logic [2:0] src,
                                     input logic [2:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: purely combinational load-use detector.
// Ports:
//   ex_opcode, ex_rd          - instruction in EX and its destination
//   id_rs, id_rt              - source registers of the instruction in ID
//   id_uses_rs, id_uses_rt    - qualifiers saying the source is actually read
//   load_use                  - EX holds a load whose result ID needs now
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ex_opcode,
  input  logic [2:0] ex_rd,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       load_use
);

  assign load_use = (ex_opcode == OP_LD) &&
                    (reg_match(id_uses_rs, id_rs, ex_rd) ||
                     reg_match(id_uses_rt, id_rt, ex_rd));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall / halt controller.
// Ports:
//   clk, rst                  - rising-edge clock, async active-low reset
//   id_*                      - ID-stage opcode, sources and qualifiers
//   ex_opcode, ex_rd          - EX-stage opcode and destination
//   ex_redirect               - taken branch/jump resolved in EX
//   mem_req, mem_done         - MEM-stage access and its completion
//   pc_write, ifid_write      - PC and IF/ID register enables
//   ifid_flush, idex_bubble   - IF/ID flush, ID/EX bubble insert
//   exmem_hold                - hold EX/MEM (memory access outstanding)
//   halt_done                 - pipeline frozen after HALT
//   stall_cnt                 - saturating count of stall cycles
//   state_dbg                 - current FSM state
//
// Memory handshake: mem_req marks an access in MEM; mem_done marks the
// cycle it completes. mem_req with mem_done in the same cycle costs
// nothing. mem_req without mem_done stalls the front end and holds
// EX/MEM until the cycle mem_done is seen; the hold drops the cycle after.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_opcode,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_opcode,
  input  logic [2:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             halt_done,
  output logic [CNT_W-1:0] stall_cnt,
  output state_t           state_dbg
);

  // Drain counter only needs to hold DRAIN_CYCLES-1 (DRAIN_CYCLES >= 1).
  localparam int          DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  state_t        state, state_n;
  logic [DW-1:0] drain_cnt, drain_n;
  logic          load_use;
  logic          mem_stall;

  // Register usage is already decoded into the id_uses_* qualifiers, so the
  // ID opcode itself carries no extra information here.
  logic unused_id_opcode;
  assign unused_id_opcode = ^id_opcode;

  hazard_detect u_detect (
    .ex_opcode  (ex_opcode),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req && !mem_done;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
    end
  end

  always_comb begin
    state_n     = state;
    drain_n     = drain_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    halt_done   = 1'b0;

    case (state)
      ST_RUN: begin
        // Priority: memory stall > redirect > load-use > HALT.
        if (mem_stall) begin
          state_n    = ST_MEM_WAIT;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          exmem_hold = 1'b1;
        end else if (ex_redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (ex_opcode == OP_HALT) begin
          state_n     = ST_DRAIN;
          drain_n     = DRAIN_INIT;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
      end

      // EX is frozen here, so redirects and hazards wait for RUN.
      ST_MEM_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        exmem_hold = 1'b1;
        if (mem_done) state_n = ST_RUN;
      end

      ST_DRAIN: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        // An outstanding access freezes the drain count.
        if (mem_stall) begin
          exmem_hold = 1'b1;
        end else if (drain_cnt == '0) begin
          state_n = ST_HALTED;
        end else begin
          drain_n = drain_cnt - DW'(1);
        end
      end

      ST_HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        exmem_hold  = 1'b1;
        idex_bubble = 1'b1;
        halt_done   = 1'b1;
      end

      default: state_n = ST_RUN;
    endcase

    // Reset values are driven straight from rst, independent of clk.
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_hold  = 1'b0;
      halt_done   = 1'b0;
    end
  end

  // Saturating stall counter; the frozen HALTED state is not a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!pc_write && (state != ST_HALTED) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam logic [4:0] OP_ADD = 5'b00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  id_opcode, ex_opcode;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_redirect, mem_req, mem_done;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, halt_done;
  logic [15:0] stall_cnt;
  state_t      state_dbg;

  logic        pc_write4, ifid_write4, ifid_flush4, idex_bubble4, exmem_hold4, halt_done4;
  logic [3:0]  stall_cnt4;
  state_t      state_dbg4;

  logic [5:0]  outs;
  assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, halt_done};

  hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_done(mem_done),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .halt_done(halt_done),
    .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_done(mem_done),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
    .idex_bubble(idex_bubble4), .exmem_hold(exmem_hold4), .halt_done(halt_done4),
    .stall_cnt(stall_cnt4), .state_dbg(state_dbg4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_opcode   = OP_ADD;
    id_rs       = 3'd0;
    id_rt       = 3'd0;
    id_uses_rs  = 1'b0;
    id_uses_rt  = 1'b0;
    ex_opcode   = OP_ADD;
    ex_rd       = 3'd7;
    ex_redirect = 1'b0;
    mem_req     = 1'b0;
    mem_done    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, halt_done}
  task automatic exp_cycle(input string tag, input logic [5:0] exp_outs, input state_t exp_st);
    #3;
    check(tag, {26'd0, outs}, {26'd0, exp_outs});
    check({tag, "_st"}, {30'd0, state_dbg}, {30'd0, exp_st});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_idle();
    tick();
    tick();
    rst = 1'b1;
    exp_cycle("rst_release", 6'b110000, ST_RUN);
    check("rst_release_cnt", {16'd0, stall_cnt}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    set_idle();
    #2;
    check("rst_outs", {26'd0, outs}, 32'b001100);
    check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_st", {30'd0, state_dbg}, {30'd0, ST_RUN});
    tick();
    tick();
    rst = 1'b1;
    exp_cycle("run_default", 6'b110000, ST_RUN);

    // Load-use hazards and their qualifiers.
    tick(); set_idle(); ex_opcode = OP_LD; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
    exp_cycle("lu_rs", 6'b000100, ST_RUN);
    tick(); set_idle();
    exp_cycle("lu_rs_after", 6'b110000, ST_RUN);
    check("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    check("lu_cnt4", {28'd0, stall_cnt4}, 32'd1);
    tick(); set_idle(); ex_opcode = OP_LD; ex_rd = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1;
    exp_cycle("lu_rt", 6'b000100, ST_RUN);
    tick(); set_idle(); ex_opcode = OP_LD; ex_rd = 3'd5; id_rs = 3'd5; id_uses_rs = 1'b0;
    id_rt = 3'd2; id_uses_rt = 1'b1;
    exp_cycle("lu_unqualified", 6'b110000, ST_RUN);
    tick(); set_idle(); ex_opcode = OP_ST; ex_rd = 3'd4; id_rs = 3'd4; id_uses_rs = 1'b1;
    exp_cycle("store_no_hazard", 6'b110000, ST_RUN);
    tick(); set_idle(); ex_redirect = 1'b1; ex_opcode = OP_LD; ex_rd = 3'd3;
    id_rs = 3'd3; id_uses_rs = 1'b1;
    exp_cycle("redirect_over_lu", 6'b111100, ST_RUN);
    tick(); set_idle();
    exp_cycle("redirect_after", 6'b110000, ST_RUN);
    check("redirect_cnt", {16'd0, stall_cnt}, 32'd2);

    // Memory stall, with a redirect + hazard pending behind it.
    do_reset();
    tick(); mem_req = 1'b1; mem_done = 1'b1;
    exp_cycle("mem_hit", 6'b110000, ST_RUN);
    tick(); set_idle(); mem_req = 1'b1; ex_redirect = 1'b1; ex_opcode = OP_LD;
    ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
    exp_cycle("mem_req", 6'b000010, ST_RUN);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cycle("mem_wait", 6'b000010, ST_MEM_WAIT);
    end
    tick(); mem_done = 1'b1;
    exp_cycle("mem_done", 6'b000010, ST_MEM_WAIT);
    tick(); mem_req = 1'b0; mem_done = 1'b0;
    exp_cycle("mem_exit_redirect", 6'b111100, ST_RUN);
    check("mem_cnt", {16'd0, stall_cnt}, 32'd5);
    tick(); set_idle();
    exp_cycle("mem_idle", 6'b110000, ST_RUN);
    check("mem_cnt_hold", {16'd0, stall_cnt}, 32'd5);

    // HALT: redirect wins first, then 2 drain cycles, then terminal HALTED.
    do_reset();
    tick(); ex_opcode = OP_HALT; ex_redirect = 1'b1;
    exp_cycle("halt_vs_redirect", 6'b111100, ST_RUN);
    tick(); ex_redirect = 1'b0;
    exp_cycle("halt_detect", 6'b001100, ST_RUN);
    tick(); set_idle();
    exp_cycle("drain1", 6'b001100, ST_DRAIN);
    tick();
    exp_cycle("drain2", 6'b001100, ST_DRAIN);
    for (int i = 0; i < 12; i++) begin
      tick();
      ex_redirect = i[0];
      exp_cycle("halted", 6'b000111, ST_HALTED);
    end
    check("halt_cnt", {16'd0, stall_cnt}, 32'd3);

    // HALT with a memory stall during drain: count must freeze.
    do_reset();
    tick(); ex_opcode = OP_HALT;
    exp_cycle("halt2_detect", 6'b001100, ST_RUN);
    tick(); set_idle(); mem_req = 1'b1;
    exp_cycle("drain_mem1", 6'b001110, ST_DRAIN);
    tick();
    exp_cycle("drain_mem2", 6'b001110, ST_DRAIN);
    tick(); mem_req = 1'b0;
    exp_cycle("drain_a", 6'b001100, ST_DRAIN);
    tick();
    exp_cycle("drain_b", 6'b001100, ST_DRAIN);
    tick();
    exp_cycle("halted2", 6'b000111, ST_HALTED);
    check("halt2_cnt", {16'd0, stall_cnt}, 32'd5);

    // Reset asserted mid-MEM_WAIT.
    do_reset();
    tick(); mem_req = 1'b1;
    exp_cycle("mw_enter", 6'b000010, ST_RUN);
    tick();
    exp_cycle("mw_wait1", 6'b000010, ST_MEM_WAIT);
    tick();
    exp_cycle("mw_wait2", 6'b000010, ST_MEM_WAIT);
    check("mw_cnt", {16'd0, stall_cnt}, 32'd2);
    rst = 1'b0;
    #1;
    check("mw_rst_outs", {26'd0, outs}, 32'b001100);
    check("mw_rst_st", {30'd0, state_dbg}, {30'd0, ST_RUN});
    check("mw_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    tick();
    tick();
    set_idle();
    rst = 1'b1;
    exp_cycle("mw_release", 6'b110000, ST_RUN);
    check("mw_release_cnt", {16'd0, stall_cnt}, 32'd0);

    // Saturation: 13 stall cycles, then 20 more; narrow counter holds at 15.
    do_reset();
    tick(); mem_req = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      tick();
      #3;
      check("sat_cnt16", {16'd0, stall_cnt}, n);
      check("sat_cnt4", {28'd0, stall_cnt4}, (n > 15) ? 32'd15 : n);
    end
    mem_done = 1'b1;
    tick(); mem_req = 1'b0; mem_done = 1'b0;
    exp_cycle("sat_exit", 6'b110000, ST_RUN);
    check("sat_final16", {16'd0, stall_cnt}, 32'd34);
    check("sat_final4", {28'd0, stall_cnt4}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
